// File: rtl/pckg_rx_block_pkg.sv
// rtl/pckg_rx_block_pkg.sv - shared framing constants, state types and channel decode
// Shared between the receive deframer, the packet builder and the transmitter.
//   SYNC_BYTE_DEF         : default packet start marker
//   HDR_CH_MSB/LSB        : channel field position in the header byte
//   HDR_LEN_MSB/LSB       : length field position in the header byte
//   FRAME_LEN             : line bits per byte (start + 8 data + stop)
//   CH_NUM                : number of downstream channels
package pckg_rx_block_pkg;

    localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
    localparam int HDR_CH_MSB  = 7;
    localparam int HDR_CH_LSB  = 6;
    localparam int HDR_LEN_MSB = 5;
    localparam int HDR_LEN_LSB = 0;
    localparam int FRAME_LEN   = 10;
    localparam int CH_NUM      = 3;

    typedef enum logic [1:0] {
        DS_IDLE,
        DS_DATA,
        DS_STOP,
        DS_WAIT
    } deser_state_t;

    typedef enum logic [1:0] {
        PS_HUNT,
        PS_HDR,
        PS_PAY,
        PS_CHK
    } parse_state_t;

    // Channel 1..3 maps to strobe bit 0..2; channel 0 never strobes.
    function automatic logic [CH_NUM-1:0] ch_onehot(input logic [1:0] ch);
        logic [CH_NUM-1:0] oh;
        case (ch)
            2'd1:    oh = 3'b001;
            2'd2:    oh = 3'b010;
            2'd3:    oh = 3'b100;
            default: oh = 3'b000;
        endcase
        return oh;
    endfunction

endpackage

// File: rtl/rx_byte_deser.sv
// rtl/rx_byte_deser.sv - one-bit-per-clock line deserializer with framing check
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   rx         : serial line, idle high
//   byte_data  : last received byte, stable while byte_vld is high
//   byte_vld   : one-cycle pulse, byte_data holds a correctly framed byte
//   fr_err     : one-cycle pulse, stop bit sampled low
module rx_byte_deser
    import pckg_rx_block_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       rx,
    output logic [7:0] byte_data,
    output logic       byte_vld,
    output logic       fr_err
);

    localparam logic [2:0] LAST_BIT = 3'(FRAME_LEN - 3);

    deser_state_t state, state_n;
    logic [2:0]   bit_cnt, bit_cnt_n;
    logic [7:0]   shift, shift_n;
    logic         vld_n, err_n;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= DS_IDLE;
            bit_cnt  <= '0;
            shift    <= '0;
            byte_vld <= 1'b0;
            fr_err   <= 1'b0;
        end else begin
            state    <= state_n;
            bit_cnt  <= bit_cnt_n;
            shift    <= shift_n;
            byte_vld <= vld_n;
            fr_err   <= err_n;
        end
    end

    always_comb begin
        state_n   = state;
        bit_cnt_n = bit_cnt;
        shift_n   = shift;
        vld_n     = 1'b0;
        err_n     = 1'b0;
        case (state)
            DS_IDLE: begin
                if (!rx) begin
                    state_n   = DS_DATA;
                    bit_cnt_n = '0;
                end
            end
            DS_DATA: begin
                // LSB first: each new bit enters at the top and shifts down.
                shift_n   = {rx, shift[7:1]};
                bit_cnt_n = bit_cnt + 3'd1;
                if (bit_cnt == LAST_BIT) begin
                    state_n = DS_STOP;
                end
            end
            DS_STOP: begin
                if (rx) begin
                    vld_n   = 1'b1;
                    state_n = DS_IDLE;
                end else begin
                    err_n   = 1'b1;
                    state_n = DS_WAIT;
                end
            end
            DS_WAIT: begin
                // A stuck-low line must not be mistaken for a run of start bits.
                if (rx) begin
                    state_n = DS_IDLE;
                end
            end
            default: state_n = DS_IDLE;
        endcase
    end

    assign byte_data = shift;

endmodule

// File: rtl/pckg_rx_block.sv
// rtl/pckg_rx_block.sv - receive deframer: sync hunt, header parse, payload delivery, XOR check
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   rx         : serial line, idle high
//   data_out   : payload byte, qualified by ch_vld
//   ch_vld     : one-hot channel strobe (bit0 = channel 1)
//   pkt_ok     : pulse, packet complete with matching checksum
//   pkt_err    : pulse, packet aborted or checksum mismatch
//   busy       : parser is inside a packet
module pckg_rx_block
    import pckg_rx_block_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE = SYNC_BYTE_DEF,
    parameter int         MAX_LEN   = 63
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rx,
    output logic [7:0]        data_out,
    output logic [CH_NUM-1:0] ch_vld,
    output logic              pkt_ok,
    output logic              pkt_err,
    output logic              busy
);

    logic [7:0] byte_data;
    logic       byte_vld;
    logic       fr_err;

    rx_byte_deser u_deser (
        .clk       (clk),
        .rst       (rst),
        .rx        (rx),
        .byte_data (byte_data),
        .byte_vld  (byte_vld),
        .fr_err    (fr_err)
    );

    parse_state_t      state, state_n;
    logic [1:0]        ch_r, ch_n;
    logic [5:0]        cnt, cnt_n;
    logic [7:0]        chk, chk_n;
    logic [7:0]        data_n;
    logic [CH_NUM-1:0] vld_n;
    logic              ok_n, err_n;

    logic [1:0] hdr_ch;
    logic [5:0] hdr_len;
    assign hdr_ch  = byte_data[HDR_CH_MSB:HDR_CH_LSB];
    assign hdr_len = byte_data[HDR_LEN_MSB:HDR_LEN_LSB];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= PS_HUNT;
            ch_r     <= '0;
            cnt      <= '0;
            chk      <= '0;
            data_out <= '0;
            ch_vld   <= '0;
            pkt_ok   <= 1'b0;
            pkt_err  <= 1'b0;
            busy     <= 1'b0;
        end else begin
            state    <= state_n;
            ch_r     <= ch_n;
            cnt      <= cnt_n;
            chk      <= chk_n;
            data_out <= data_n;
            ch_vld   <= vld_n;
            pkt_ok   <= ok_n;
            pkt_err  <= err_n;
            busy     <= (state_n != PS_HUNT);
        end
    end

    always_comb begin
        state_n = state;
        ch_n    = ch_r;
        cnt_n   = cnt;
        chk_n   = chk;
        data_n  = data_out;
        vld_n   = '0;
        ok_n    = 1'b0;
        err_n   = 1'b0;
        if (fr_err) begin
            // Line noise while hunting is expected and stays silent.
            if (state != PS_HUNT) begin
                err_n = 1'b1;
            end
            state_n = PS_HUNT;
        end else if (byte_vld) begin
            case (state)
                PS_HUNT: begin
                    if (byte_data == SYNC_BYTE) begin
                        state_n = PS_HDR;
                    end
                end
                PS_HDR: begin
                    ch_n  = hdr_ch;
                    cnt_n = hdr_len;
                    chk_n = byte_data;
                    if (hdr_ch == 2'd0 || hdr_len == 6'd0 || int'(hdr_len) > MAX_LEN) begin
                        err_n   = 1'b1;
                        state_n = PS_HUNT;
                    end else begin
                        state_n = PS_PAY;
                    end
                end
                PS_PAY: begin
                    data_n = byte_data;
                    vld_n  = ch_onehot(ch_r);
                    chk_n  = chk ^ byte_data;
                    cnt_n  = cnt - 6'd1;
                    if (cnt == 6'd1) begin
                        state_n = PS_CHK;
                    end
                end
                PS_CHK: begin
                    if (byte_data == chk) begin
                        ok_n = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                    state_n = PS_HUNT;
                end
                default: state_n = PS_HUNT;
            endcase
        end
    end

endmodule

// File: tb/tb_pckg_rx_block.sv
// tb/tb_pckg_rx_block.sv - directed self-checking bench for pckg_rx_block
module tb_pckg_rx_block;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       rx  = 1'b1;
    logic [7:0] data_out;
    logic [2:0] ch_vld;
    logic       pkt_ok;
    logic       pkt_err;
    logic       busy;

    pckg_rx_block dut (
        .clk      (clk),
        .rst      (rst),
        .rx       (rx),
        .data_out (data_out),
        .ch_vld   (ch_vld),
        .pkt_ok   (pkt_ok),
        .pkt_err  (pkt_err),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errs   = 0;

    logic [10:0] got_q[$];
    logic [10:0] exp_q[$];
    int          ok_cnt   = 0;
    int          err_cnt  = 0;
    int          viol_cnt = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errs++;
            $display("FAIL %s got %0h expected %0h", tag, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (ch_vld != 3'b000) got_q.push_back({ch_vld, data_out});
            if (pkt_ok) ok_cnt++;
            if (pkt_err) err_cnt++;
            if (pkt_ok && pkt_err) viol_cnt++;
            if ((ch_vld != 3'b000) && (pkt_ok || pkt_err)) viol_cnt++;
            if ($countones(ch_vld) > 1) viol_cnt++;
            if ((ch_vld != 3'b000) && !busy) viol_cnt++;
        end
    end

    task automatic send_byte(input logic [7:0] b, input bit bad_stop);
        rx = 1'b0;
        @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx = b[i];
            @(negedge clk);
        end
        rx = bad_stop ? 1'b0 : 1'b1;
        @(negedge clk);
    endtask

    task automatic send_q(input logic [7:0] q[$]);
        foreach (q[i]) send_byte(q[i], 1'b0);
    endtask

    task automatic idle(input int n);
        rx = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    task automatic check_log(input string tag, input int exp_ok, input int exp_err);
        int n;
        check({tag, "_nstrobe"}, got_q.size(), exp_q.size());
        n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_strobe%0d", tag, i), {21'd0, got_q[i]}, {21'd0, exp_q[i]});
        end
        check({tag, "_ok"}, ok_cnt, exp_ok);
        check({tag, "_err"}, err_cnt, exp_err);
        got_q.delete();
        exp_q.delete();
        ok_cnt  = 0;
        err_cnt = 0;
    endtask

    initial begin
        // Reset state
        rst = 1'b1;
        rx  = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_data", {24'd0, data_out}, 32'h0);
        check("rst_vld", {29'd0, ch_vld}, 32'h0);
        check("rst_ok", {31'd0, pkt_ok}, 32'h0);
        check("rst_err", {31'd0, pkt_err}, 32'h0);
        check("rst_busy", {31'd0, busy}, 32'h0);
        rst = 1'b0;
        idle(3);

        // Clean packet, ch1 len3; CHK = 43^11^22^33 = 43
        send_q('{8'hA5, 8'h43, 8'h11, 8'h22, 8'h33});
        check("busy_in_pkt", {31'd0, busy}, 32'h1);
        send_byte(8'h43, 1'b0);
        check("ok_early", {31'd0, pkt_ok}, 32'h0);
        @(negedge clk);
        check("ok_latency", {31'd0, pkt_ok}, 32'h1);
        check("busy_fall", {31'd0, busy}, 32'h0);
        @(negedge clk);
        check("ok_width", {31'd0, pkt_ok}, 32'h0);
        idle(2);
        exp_q = '{{3'b001, 8'h11}, {3'b001, 8'h22}, {3'b001, 8'h33}};
        check_log("clean", 1, 0);

        // Bad checksum
        send_q('{8'hA5, 8'h43, 8'h11, 8'h22, 8'h33, 8'h44});
        idle(4);
        exp_q = '{{3'b001, 8'h11}, {3'b001, 8'h22}, {3'b001, 8'h33}};
        check_log("badchk", 0, 1);

        // Noise then ch=0 header
        send_q('{8'h00, 8'h5A, 8'hA5, 8'h03});
        idle(4);
        check_log("badhdr", 0, 1);

        // ch3 len1; CHK = C1^7E = BF
        send_q('{8'hA5, 8'hC1, 8'h7E, 8'hBF});
        idle(4);
        exp_q = '{{3'b100, 8'h7E}};
        check_log("ch3", 1, 0);

        // Framing error on 2nd payload byte, then line stuck low
        send_q('{8'hA5, 8'h44, 8'h01});
        send_byte(8'h02, 1'b1);
        rx = 1'b0;
        repeat (20) @(negedge clk);
        idle(4);
        exp_q = '{{3'b001, 8'h01}};
        check_log("framing", 0, 1);

        // Recovery: ch2 len2; CHK = 82^AA^55 = 7D
        send_q('{8'hA5, 8'h82, 8'hAA, 8'h55, 8'h7D});
        idle(4);
        exp_q = '{{3'b010, 8'hAA}, {3'b010, 8'h55}};
        check_log("recover", 1, 0);

        // Back-to-back, zero idle bits
        send_q('{8'hA5, 8'h82, 8'hAA, 8'h55, 8'h7D, 8'hA5, 8'h82, 8'hAA, 8'h55, 8'h7D});
        idle(4);
        exp_q = '{{3'b010, 8'hAA}, {3'b010, 8'h55}, {3'b010, 8'hAA}, {3'b010, 8'h55}};
        check_log("b2b", 2, 0);

        // Reset during payload byte 2
        send_q('{8'hA5, 8'h43, 8'h11});
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b0;
        @(negedge clk);
        rx = 1'b1;
        @(negedge clk);
        check("pre_rst_busy", {31'd0, busy}, 32'h1);
        #2;
        rst = 1'b1;
        #1;
        check("mid_rst_busy", {31'd0, busy}, 32'h0);
        check("mid_rst_vld", {29'd0, ch_vld}, 32'h0);
        check("mid_rst_data", {24'd0, data_out}, 32'h0);
        check("mid_rst_err", {31'd0, pkt_err}, 32'h0);
        rx = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        idle(3);
        exp_q = '{{3'b001, 8'h11}};
        check_log("pre_rst", 0, 0);

        send_q('{8'hA5, 8'h43, 8'h11, 8'h22, 8'h33, 8'h43});
        idle(4);
        exp_q = '{{3'b001, 8'h11}, {3'b001, 8'h22}, {3'b001, 8'h33}};
        check_log("post_rst", 1, 0);

        check("invariants", viol_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errs);
        $finish;
    end

endmodule
